// File: rtl/nand_flash_responder.sv
// Flash-device side of the 8-bit NAND interface: decodes CLE/ALE/WEN/REN strobes,
// keeps pages in an internal array and reports ready/busy on F_RB.
module nand_flash_responder #(
  parameter int PAGE_SIZE = 512,
  parameter int ROW_BITS  = 9,
  parameter int T_R       = 8,
  parameter int T_PROG    = 16,
  parameter int T_RST     = 4
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire  [7:0] F_IO,
  input  logic       F_CLE,
  input  logic       F_ALE,
  input  logic       F_WEN,
  input  logic       F_REN,
  output logic       F_RB,
  output logic [3:0] dbg_state,
  output logic       dbg_oe
);

  localparam int COL_W  = $clog2(PAGE_SIZE);
  localparam int ADDR_W = ROW_BITS + COL_W;
  localparam int CNT_W  = $clog2(PAGE_SIZE + T_PROG + T_R + T_RST + 1);

  localparam logic [CNT_W-1:0] COPY_END  = CNT_W'(PAGE_SIZE);
  localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(PAGE_SIZE + T_R - 1);
  localparam logic [CNT_W-1:0] PG_LAST   = CNT_W'(PAGE_SIZE + T_PROG - 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(T_RST - 1);
  localparam logic [COL_W-1:0] COL_MAX   = COL_W'(PAGE_SIZE - 1);
  localparam logic [COL_W-1:0] HALF_BASE = COL_W'(256);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_BUSY_RD  = 3'd2,
    ST_RD_OUT   = 3'd3,
    ST_PROG_LD  = 3'd4,
    ST_BUSY_PG  = 3'd5,
    ST_BUSY_RST = 3'd6
  } state_t;

  state_t               state;
  logic                 wen_q;
  logic                 ren_q;
  logic                 rb;
  logic                 oe;
  logic [7:0]           dout;
  logic [7:0]           cmd;
  logic [COL_W-1:0]     col;
  logic [ROW_BITS-1:0]  row;
  logic [1:0]           addr_cnt;
  logic                 prog;
  logic                 col_full;
  logic                 stat_mode;
  logic [CNT_W-1:0]     cnt;
  logic [PAGE_SIZE-1:0] loaded;

  logic [7:0] mem  [2**ADDR_W];
  logic [7:0] pbuf [PAGE_SIZE];

  logic             wen_rise, ren_fall, ren_rise;
  logic             cmd_stb, addr_stb, data_stb;
  logic             busy, copying;
  logic [COL_W-1:0] copy_idx;
  logic [ADDR_W-1:0] copy_addr;
  logic             mem_we;
  logic [7:0]       mem_wdata;
  logic             buf_we;
  logic [COL_W-1:0] buf_waddr;
  logic [7:0]       buf_wdata;

  assign wen_rise = F_WEN & ~wen_q;
  assign ren_fall = ~F_REN & ren_q;
  assign ren_rise = F_REN & ~ren_q;
  assign cmd_stb  = wen_rise & F_CLE & ~F_ALE;
  assign addr_stb = wen_rise & F_ALE & ~F_CLE;
  assign data_stb = wen_rise & ~F_CLE & ~F_ALE;

  assign busy      = (state == ST_BUSY_RD) || (state == ST_BUSY_PG) || (state == ST_BUSY_RST);
  assign copying   = (cnt < COPY_END);
  assign copy_idx  = cnt[COL_W-1:0];
  assign copy_addr = {row, copy_idx};

  // Bytes never loaded since the last 80h read back as erased (FFh).
  assign mem_wdata = loaded[copy_idx] ? pbuf[copy_idx] : 8'hFF;

  always_comb begin
    mem_we    = 1'b0;
    buf_we    = 1'b0;
    buf_waddr = col;
    buf_wdata = F_IO;
    if (state == ST_BUSY_PG && copying) mem_we = 1'b1;
    if (state == ST_BUSY_RD && copying) begin
      buf_we    = 1'b1;
      buf_waddr = copy_idx;
      buf_wdata = mem[copy_addr];
    end else if (state == ST_PROG_LD && data_stb && !col_full) begin
      buf_we = 1'b1;
    end
  end

  // Storage is not reset: page contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) mem[copy_addr] <= mem_wdata;
    if (buf_we) pbuf[buf_waddr] <= buf_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      wen_q     <= 1'b1;
      ren_q     <= 1'b1;
      rb        <= 1'b1;
      oe        <= 1'b0;
      dout      <= 8'h00;
      cmd       <= 8'h00;
      col       <= '0;
      row       <= '0;
      addr_cnt  <= 2'd0;
      prog      <= 1'b0;
      col_full  <= 1'b0;
      stat_mode <= 1'b0;
      cnt       <= '0;
      loaded    <= '0;
    end else begin
      wen_q <= F_WEN;
      ren_q <= F_REN;

      if (ren_fall) begin
        if (stat_mode) begin
          oe   <= 1'b1;
          dout <= rb ? 8'hC0 : 8'h80;
        end else if (state == ST_RD_OUT) begin
          oe   <= 1'b1;
          dout <= pbuf[col];
        end
      end else if (ren_rise) begin
        oe <= 1'b0;
        if (stat_mode) stat_mode <= 1'b0;
        else if (state == ST_RD_OUT && col != COL_MAX) col <= col + 1'b1;
      end
      if (~F_WEN | F_CLE | F_ALE) oe <= 1'b0;

      case (state)
        ST_BUSY_RD: begin
          if (cnt == RD_LAST) begin
            rb    <= 1'b1;
            state <= ST_RD_OUT;
          end else cnt <= cnt + 1'b1;
        end
        ST_BUSY_PG: begin
          if (cnt == PG_LAST) begin
            rb    <= 1'b1;
            state <= ST_IDLE;
          end else cnt <= cnt + 1'b1;
        end
        ST_BUSY_RST: begin
          if (cnt == RST_LAST) begin
            rb    <= 1'b1;
            state <= ST_IDLE;
          end else cnt <= cnt + 1'b1;
        end
        default: ;
      endcase

      if (addr_stb && state == ST_ADDR) begin
        addr_cnt <= addr_cnt + 1'b1;
        case (addr_cnt)
          2'd0: col <= ((cmd == 8'h01) ? HALF_BASE : '0) + COL_W'(F_IO);
          2'd1: row[7:0] <= F_IO;
          default: begin
            row[ROW_BITS-1:8] <= F_IO[ROW_BITS-9:0];
            if (prog) state <= ST_PROG_LD;
            else begin
              state <= ST_BUSY_RD;
              rb    <= 1'b0;
              cnt   <= '0;
            end
          end
        endcase
      end

      if (data_stb && state == ST_PROG_LD && !col_full) begin
        loaded[col] <= 1'b1;
        if (col == COL_MAX) col_full <= 1'b1;
        else col <= col + 1'b1;
      end

      // Commands last so FFh overrides any counter step in the same cycle.
      if (cmd_stb) begin
        if (F_IO == 8'hFF) begin
          cmd       <= 8'hFF;
          state     <= ST_BUSY_RST;
          rb        <= 1'b0;
          cnt       <= '0;
          stat_mode <= 1'b0;
        end else if (F_IO == 8'h70) begin
          cmd       <= 8'h70;
          stat_mode <= 1'b1;
        end else if (!busy) begin
          case (F_IO)
            8'h00, 8'h01: begin
              cmd       <= F_IO;
              state     <= ST_ADDR;
              addr_cnt  <= 2'd0;
              prog      <= 1'b0;
              col       <= '0;
              stat_mode <= 1'b0;
            end
            8'h80: begin
              cmd       <= 8'h80;
              state     <= ST_ADDR;
              addr_cnt  <= 2'd0;
              prog      <= 1'b1;
              col       <= '0;
              col_full  <= 1'b0;
              loaded    <= '0;
              stat_mode <= 1'b0;
            end
            8'h10: begin
              if (state == ST_PROG_LD) begin
                cmd       <= 8'h10;
                state     <= ST_BUSY_PG;
                rb        <= 1'b0;
                cnt       <= '0;
                stat_mode <= 1'b0;
              end
            end
            default: begin
              state     <= ST_IDLE;
              stat_mode <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign F_RB      = rb;
  assign dbg_oe    = oe & F_WEN & ~F_CLE & ~F_ALE;
  assign dbg_state = {stat_mode, state};
  assign F_IO      = dbg_oe ? dout : 8'bz;

endmodule

// File: tb/tb_nand_flash_responder.sv
// Bench for nand_flash_responder: command table, directed corner sequences and
// randomized program/read traffic checked against a page-level reference model.
module tb_nand_flash_responder;

  localparam int PAGE   = 512;
  localparam int T_R    = 8;
  localparam int T_PROG = 16;
  localparam int T_RST  = 4;

  localparam logic [3:0] D_IDLE    = 4'h0;
  localparam logic [3:0] D_ADDR    = 4'h1;
  localparam logic [3:0] D_BUSY_RD = 4'h2;
  localparam logic [3:0] D_RD_OUT  = 4'h3;
  localparam logic [3:0] D_STAT    = 4'h8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  wire  [7:0] F_IO;
  logic       F_CLE = 1'b0;
  logic       F_ALE = 1'b0;
  logic       F_WEN = 1'b1;
  logic       F_REN = 1'b1;
  logic       F_RB;
  logic [3:0] dbg_state;
  logic       dbg_oe;
  logic       tb_io_en = 1'b0;
  logic [7:0] tb_io = 8'h00;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] prog_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] model_mem [int];

  assign F_IO = tb_io_en ? tb_io : 8'bz;

  nand_flash_responder #(
    .PAGE_SIZE(PAGE), .ROW_BITS(9), .T_R(T_R), .T_PROG(T_PROG), .T_RST(T_RST)
  ) dut (
    .clk(clk), .rst(rst), .F_IO(F_IO), .F_CLE(F_CLE), .F_ALE(F_ALE),
    .F_WEN(F_WEN), .F_REN(F_REN), .F_RB(F_RB), .dbg_state(dbg_state), .dbg_oe(dbg_oe)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1500000;
    n_errors++;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // scoreboard helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_program(input int row, input int col0);
    for (int c = 0; c < PAGE; c++) model_mem[row * PAGE + c] = 8'hFF;
    foreach (prog_q[i])
      if (col0 + i < PAGE) model_mem[row * PAGE + col0 + i] = prog_q[i];
  endfunction

  function automatic logic [7:0] model_byte(input int row, input int c);
    int cc;
    cc = (c > PAGE - 1) ? PAGE - 1 : c;
    return model_mem[row * PAGE + cc];
  endfunction

  // driver tasks
  task automatic bus_idle();
    F_CLE = 1'b0;
    F_ALE = 1'b0;
    tb_io_en = 1'b0;
  endtask

  task automatic latch(input logic cle, input logic ale, input logic [7:0] b);
    @(negedge clk);
    F_CLE = cle; F_ALE = ale; tb_io = b; tb_io_en = 1'b1; F_WEN = 1'b0;
    @(negedge clk);
    F_WEN = 1'b1;
  endtask

  task automatic send_addr(input logic [7:0] colb, input logic [15:0] row);
    latch(1'b0, 1'b1, colb);
    latch(1'b0, 1'b1, row[7:0]);
    latch(1'b0, 1'b1, row[15:8]);
  endtask

  task automatic measure_busy(output int n);
    n = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      bus_idle();
      if (F_RB) return;
      n++;
    end
    n_checks++;
    n_errors++;
    $display("FAIL busy_timeout: RB still 0 after %0d cycles, required 1", n);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (F_RB) return;
    end
    n_checks++;
    n_errors++;
    $display("FAIL ready_timeout: RB=0 after 4000 cycles, required 1");
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ren_read(output logic [7:0] d, output logic o);
    @(negedge clk);
    bus_idle();
    F_REN = 1'b0;
    @(negedge clk);
    o = dbg_oe;
    d = F_IO;
    F_REN = 1'b1;
  endtask

  task automatic do_program(input int row, input logic [7:0] col0);
    int n;
    latch(1'b1, 1'b0, 8'h80);
    send_addr(col0, 16'(row));
    foreach (prog_q[i]) latch(1'b0, 1'b0, prog_q[i]);
    latch(1'b1, 1'b0, 8'h10);
    measure_busy(n);
    check($sformatf("prog_busy row%0d", row), n, PAGE + T_PROG);
    model_program(row, int'(col0));
  endtask

  task automatic do_read(input logic [7:0] c, input logic [7:0] colb, input int row, input int pulses);
    int n;
    int start;
    logic [7:0] d;
    logic o;
    logic [7:0] e;
    latch(1'b1, 1'b0, c);
    send_addr(colb, 16'(row));
    measure_busy(n);
    check($sformatf("read_busy row%0d", row), n, PAGE + T_R);
    start = ((c == 8'h01) ? 256 : 0) + int'(colb);
    for (int k = 0; k < pulses; k++) exp_q.push_back(model_byte(row, start + k));
    for (int k = 0; k < pulses; k++) begin
      ren_read(d, o);
      e = exp_q.pop_front();
      check($sformatf("read r%0d c%0d", row, start + k), {o, d}, {1'b1, e});
    end
  endtask

  typedef struct {
    logic [7:0] cmd;
    int         exp_busy;
    logic [3:0] exp_dbg;
    logic       exp_oe;
    logic [7:0] exp_io;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int n;
    logic [7:0] d;
    logic o;
    int row;
    int nb;
    logic [7:0] col0;

    vecs[0]  = '{8'h70, 0,     D_STAT | D_IDLE, 1'b1, 8'hC0};
    vecs[1]  = '{8'h55, 0,     D_IDLE,          1'b0, 8'h00};
    vecs[2]  = '{8'h10, 0,     D_IDLE,          1'b0, 8'h00};
    vecs[3]  = '{8'hFF, T_RST, D_IDLE,          1'b0, 8'h00};
    vecs[4]  = '{8'h00, 0,     D_ADDR,          1'b0, 8'h00};
    vecs[5]  = '{8'h70, 0,     D_STAT | D_ADDR, 1'b1, 8'hC0};
    vecs[6]  = '{8'h10, 0,     D_ADDR,          1'b0, 8'h00};
    vecs[7]  = '{8'h80, 0,     D_ADDR,          1'b0, 8'h00};
    vecs[8]  = '{8'h10, 0,     D_ADDR,          1'b0, 8'h00};
    vecs[9]  = '{8'hA5, 0,     D_IDLE,          1'b0, 8'h00};
    vecs[10] = '{8'h01, 0,     D_ADDR,          1'b0, 8'h00};
    vecs[11] = '{8'hFF, T_RST, D_IDLE,          1'b0, 8'h00};

    // reset state
    wait_cycles(3);
    check("reset_rb", F_RB, 1'b1);
    check("reset_oe", dbg_oe, 1'b0);
    check("reset_state", dbg_state, D_IDLE);
    rst = 1'b0;
    wait_cycles(2);

    // single-command table
    for (int i = 0; i < 12; i++) begin
      latch(1'b1, 1'b0, vecs[i].cmd);
      measure_busy(n);
      check($sformatf("vec%0d_busy", i), n, vecs[i].exp_busy);
      check($sformatf("vec%0d_state", i), dbg_state, vecs[i].exp_dbg);
      ren_read(d, o);
      check($sformatf("vec%0d_oe", i), o, vecs[i].exp_oe);
      if (vecs[i].exp_oe) check($sformatf("vec%0d_io", i), d, vecs[i].exp_io);
    end

    // program page 5 with i[7:0], read it back in full
    prog_q.delete();
    for (int i = 0; i < 512; i++) prog_q.push_back(8'(i));
    do_program(5, 8'h00);
    do_read(8'h00, 8'h00, 5, 512);

    // half-page read from column 272, running past the end of the page
    do_read(8'h01, 8'h10, 5, 300);

    // status while busy, ignored read command while busy
    latch(1'b1, 1'b0, 8'h00);
    send_addr(8'h00, 16'd5);
    wait_cycles(10);
    check("stat_busy_rb", F_RB, 1'b0);
    latch(1'b1, 1'b0, 8'h70);
    wait_cycles(1);
    check("stat_busy_state", dbg_state, D_STAT | D_BUSY_RD);
    ren_read(d, o);
    check("stat_busy_io", {o, d}, {1'b1, 8'h80});
    latch(1'b1, 1'b0, 8'h00);
    wait_cycles(1);
    bus_idle();
    check("cmd_while_busy_state", dbg_state, D_BUSY_RD);
    wait_ready();
    latch(1'b1, 1'b0, 8'h70);
    wait_cycles(1);
    bus_idle();
    check("stat_ready_state", dbg_state, D_STAT | D_RD_OUT);
    ren_read(d, o);
    check("stat_ready_io", {o, d}, {1'b1, 8'hC0});
    ren_read(d, o);
    check("resume_read_c0", {o, d}, {1'b1, model_byte(5, 0)});

    // overrun program on page 7 between two known neighbours
    prog_q.delete();
    for (int i = 0; i < 512; i++) prog_q.push_back(8'(i * 3 + 1));
    do_program(6, 8'h00);
    prog_q.delete();
    for (int i = 0; i < 512; i++) prog_q.push_back(8'(i) ^ 8'h5A);
    do_program(8, 8'h00);
    prog_q.delete();
    for (int i = 0; i < 600; i++) prog_q.push_back(8'(i * 7));
    do_program(7, 8'h00);
    do_read(8'h00, 8'h00, 6, 512);
    do_read(8'h00, 8'h00, 7, 512);
    do_read(8'h00, 8'h00, 8, 512);

    // abort a read with FFh
    latch(1'b1, 1'b0, 8'h00);
    send_addr(8'h00, 16'd6);
    wait_cycles(20);
    latch(1'b1, 1'b0, 8'hFF);
    measure_busy(n);
    check("abort_busy", n, T_RST);
    check("abort_state", dbg_state, D_IDLE);
    ren_read(d, o);
    check("abort_ren_oe0", o, 1'b0);
    ren_read(d, o);
    check("abort_ren_oe1", o, 1'b0);

    // asynchronous rst in the middle of a program transfer
    prog_q.delete();
    for (int i = 0; i < 40; i++) prog_q.push_back(8'(i + 100));
    latch(1'b1, 1'b0, 8'h80);
    send_addr(8'h00, 16'd9);
    foreach (prog_q[i]) latch(1'b0, 1'b0, prog_q[i]);
    latch(1'b1, 1'b0, 8'h10);
    wait_cycles(30);
    check("rst_pre_rb", F_RB, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("rst_async_rb", F_RB, 1'b1);
    check("rst_async_oe", dbg_oe, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    check("rst_state", dbg_state, D_IDLE);
    latch(1'b1, 1'b0, 8'h70);
    ren_read(d, o);
    check("rst_status", {o, d}, {1'b1, 8'hC0});

    // randomized program/read traffic
    for (int it = 0; it < 4; it++) begin
      row  = int'($urandom_range(20, 40));
      col0 = 8'($urandom_range(0, 255));
      nb   = int'($urandom_range(1, 700));
      prog_q.delete();
      for (int i = 0; i < nb; i++) prog_q.push_back(8'($urandom_range(0, 255)));
      do_program(row, col0);
      for (int r = 0; r < 3; r++)
        do_read(($urandom_range(0, 1) != 0) ? 8'h01 : 8'h00, 8'($urandom_range(0, 255)),
                row, int'($urandom_range(1, 48)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
